// File: rtl/spi_master_if.sv
// Command/response bundle between host logic and spi_master.
// The host drives commands through 'master'; spi_master connects through 'slave'.
interface spi_master_if;
    logic       cmd_valid;
    logic [9:0] cmd_data;
    logic       cmd_ready;
    logic [7:0] rd_data;
    logic       rd_valid;

    modport master (
        output cmd_valid,
        output cmd_data,
        input  cmd_ready,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        output cmd_ready,
        output rd_data,
        output rd_valid
    );
endinterface

// File: rtl/spi_master.sv
// SPI command master: 11-bit command shift, optional read wait and 8-bit read-back.
// Define SPI_MASTER_MISO_SYNC_EN to insert a 2-flop miso synchronizer (adds 2 wait cycles).
module spi_master #(
    parameter int unsigned RD_WAIT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_master_if.slave    bus,
    output logic           busy,
    output logic           MOSI,
    output logic           SS_n,
    input  logic           miso
);

    logic miso_s;

`ifdef SPI_MASTER_MISO_SYNC_EN
    localparam int unsigned WAIT_CYC = RD_WAIT + 2;
    logic [1:0] miso_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) miso_sync <= 2'b00;
        else        miso_sync <= {miso_sync[0], miso};
    end
    assign miso_s = miso_sync[1];
`else
    localparam int unsigned WAIT_CYC = RD_WAIT;
    assign miso_s = miso;
`endif

    localparam int unsigned WAIT_LAST_I = (WAIT_CYC == 0) ? 0 : WAIT_CYC - 1;
    localparam logic [4:0]  WAIT_LAST   = WAIT_LAST_I[4:0];

    typedef enum logic [2:0] {IDLE, SHIFT, WAIT, READ, GAP} state_t;

    state_t     state, state_nxt;
    logic [4:0] cnt, cnt_nxt;
    logic [9:0] sh, sh_nxt;
    logic       rd_op, rd_op_nxt;
    logic [7:0] rx, rx_nxt;
    logic [7:0] rd_data_q, rd_data_nxt;
    logic       rd_valid_q, rd_valid_nxt;
    logic       mosi_q, mosi_nxt;
    logic       ss_n_q, ss_n_nxt;
    logic       busy_q, busy_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 5'd0;
            sh         <= 10'd0;
            rd_op      <= 1'b0;
            rx         <= 8'h00;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sh         <= sh_nxt;
            rd_op      <= rd_op_nxt;
            rx         <= rx_nxt;
            rd_data_q  <= rd_data_nxt;
            rd_valid_q <= rd_valid_nxt;
            mosi_q     <= mosi_nxt;
            ss_n_q     <= ss_n_nxt;
            busy_q     <= busy_nxt;
        end
    end

    // Outputs are registered from the next state so pins change only on clock edges.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        sh_nxt       = sh;
        rd_op_nxt    = rd_op;
        rx_nxt       = rx;
        rd_data_nxt  = rd_data_q;
        rd_valid_nxt = 1'b0;
        mosi_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = 5'd0;
                    sh_nxt    = bus.cmd_data;
                    rd_op_nxt = (bus.cmd_data[9:8] == 2'b11);
                    mosi_nxt  = bus.cmd_data[9];
                end
            end
            SHIFT: begin
                // First cycle repeats bit 9 as the rd/wr select, then all ten bits follow.
                if (cnt == 5'd10) begin
                    cnt_nxt = 5'd0;
                    if (rd_op) state_nxt = (WAIT_CYC == 0) ? READ : WAIT;
                    else       state_nxt = GAP;
                end else begin
                    cnt_nxt  = cnt + 5'd1;
                    mosi_nxt = sh[9];
                    sh_nxt   = {sh[8:0], 1'b0};
                end
            end
            WAIT: begin
                if (cnt == WAIT_LAST) begin
                    cnt_nxt   = 5'd0;
                    state_nxt = READ;
                end else begin
                    cnt_nxt = cnt + 5'd1;
                end
            end
            READ: begin
                rx_nxt = {rx[6:0], miso_s};
                if (cnt == 5'd7) begin
                    cnt_nxt      = 5'd0;
                    state_nxt    = GAP;
                    rd_data_nxt  = {rx[6:0], miso_s};
                    rd_valid_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 5'd1;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        ss_n_nxt = (state_nxt == IDLE) || (state_nxt == GAP);
        busy_nxt = (state_nxt != IDLE);
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign MOSI          = mosi_q;
    assign SS_n          = ss_n_q;
    assign busy          = busy_q;

endmodule
